// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: IF/ID/EX/MEM/WB sequencer driving Fetch plus imem/dmem req/ack handshakes.
// Define MC_PERF_CNT_EN to add the cycle_cnt/instr_cnt performance counters.
module multicycle_ctrl #(
   parameter int TIMEOUT = 15,
   parameter int TMO_W   = 4
) (
   input  logic        Clock,
   input  logic        Reset,
   input  logic [5:0]  Opcode,
   input  logic [5:0]  Funct,
   input  logic        Zero,
   input  logic        imem_ack,
   input  logic        dmem_ack,
   output logic        imem_req,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic        IRWrite,
   output logic        PCWrite,
   output logic        Jump,
   output logic        Branch,
   output logic        RegWrite,
   output logic        MemToReg,
   output logic        ALUSrc,
   output logic        RegDst,
   output logic [1:0]  ALUOp,
   output logic        halt,
   output logic        err,
`ifdef MC_PERF_CNT_EN
   output logic [31:0] cycle_cnt,
   output logic [31:0] instr_cnt,
`endif
   output logic [2:0]  state
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_IF   = 3'd1;
   localparam logic [2:0] S_ID   = 3'd2;
   localparam logic [2:0] S_EX   = 3'd3;
   localparam logic [2:0] S_MEM  = 3'd4;
   localparam logic [2:0] S_WB   = 3'd5;
   localparam logic [2:0] S_HALT = 3'd6;
   localparam logic [2:0] S_ERR  = 3'd7;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_HALT = 6'b111111;

   logic [2:0]       state_q, state_d;
   logic [TMO_W-1:0] tmo_q, tmo_d;
   logic             waiting;
   logic             tmo_hit;

   // Funct feeds ALU control and Zero feeds Fetch directly; neither steers sequencing.
   logic unused_inputs;
   assign unused_inputs = ^{Funct, Zero};

   assign tmo_hit = (tmo_q == TMO_W'(TIMEOUT));

   always_comb begin
      state_d  = state_q;
      waiting  = 1'b0;
      imem_req = 1'b0;
      dmem_req = 1'b0;
      dmem_we  = 1'b0;
      IRWrite  = 1'b0;
      PCWrite  = 1'b0;
      Jump     = 1'b0;
      Branch   = 1'b0;
      RegWrite = 1'b0;
      MemToReg = 1'b0;
      ALUSrc   = 1'b0;
      RegDst   = 1'b0;
      ALUOp    = 2'b00;
      case (state_q)
         S_IDLE: state_d = S_IF;
         S_IF: begin
            imem_req = 1'b1;
            if (imem_ack) begin
               IRWrite = 1'b1;
               state_d = S_ID;
            end else if (tmo_hit) begin
               state_d = S_ERR;
            end else begin
               waiting = 1'b1;
            end
         end
         S_ID: begin
            case (Opcode)
               OP_J: begin
                  PCWrite = 1'b1;
                  Jump    = 1'b1;
                  state_d = S_IF;
               end
               OP_HALT:                             state_d = S_HALT;
               OP_R, OP_ADDI, OP_LW, OP_SW, OP_BEQ: state_d = S_EX;
               default:                             state_d = S_ERR;
            endcase
         end
         S_EX: begin
            case (Opcode)
               OP_R: begin
                  ALUOp   = 2'b10;
                  RegDst  = 1'b1;
                  state_d = S_WB;
               end
               OP_ADDI: begin
                  ALUSrc  = 1'b1;
                  state_d = S_WB;
               end
               OP_LW, OP_SW: begin
                  ALUSrc  = 1'b1;
                  state_d = S_MEM;
               end
               // Fetch qualifies Branch with Zero itself, so PCWrite fires either way.
               OP_BEQ: begin
                  ALUOp   = 2'b01;
                  Branch  = 1'b1;
                  PCWrite = 1'b1;
                  state_d = S_IF;
               end
               default: state_d = S_ERR;
            endcase
         end
         S_MEM: begin
            dmem_req = 1'b1;
            dmem_we  = (Opcode == OP_SW);
            ALUSrc   = 1'b1;
            if (dmem_ack) begin
               if (Opcode == OP_SW) begin
                  PCWrite = 1'b1;
                  state_d = S_IF;
               end else begin
                  state_d = S_WB;
               end
            end else if (tmo_hit) begin
               state_d = S_ERR;
            end else begin
               waiting = 1'b1;
            end
         end
         S_WB: begin
            RegWrite = 1'b1;
            PCWrite  = 1'b1;
            MemToReg = (Opcode == OP_LW);
            RegDst   = (Opcode == OP_R);
            state_d  = S_IF;
         end
         S_HALT:  state_d = S_HALT;
         default: state_d = S_ERR;
      endcase
   end

   always_comb begin
      tmo_d = '0;
      if (state_d == state_q && waiting) tmo_d = tmo_q + 1'b1;
   end

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state_q <= S_IDLE;
         tmo_q   <= '0;
      end else begin
         state_q <= state_d;
         tmo_q   <= tmo_d;
      end
   end

   assign halt  = (state_q == S_HALT);
   assign err   = (state_q == S_ERR);
   assign state = state_q;

`ifdef MC_PERF_CNT_EN
   logic [31:0] cycle_cnt_q, instr_cnt_q;

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         cycle_cnt_q <= '0;
         instr_cnt_q <= '0;
      end else begin
         if (state_q != S_IDLE && state_q != S_HALT && state_q != S_ERR)
            cycle_cnt_q <= cycle_cnt_q + 32'd1;
         if (PCWrite)
            instr_cnt_q <= instr_cnt_q + 32'd1;
      end
   end

   assign cycle_cnt = cycle_cnt_q;
   assign instr_cnt = instr_cnt_q;
`endif

endmodule
